// File: rtl/screen_rotate_quad_if.sv
// screen_rotate_quad_if: source video in / rotated video out bundle; ROTATE_MIRROR_EN adds the mirror control
interface screen_rotate_quad_if #(parameter int DEPTH = 8) ();
  logic             ce_in;
  logic [DEPTH-1:0] video_in;
  logic             hblank;
  logic             vblank;
  logic [1:0]       rot;
  logic             ce_out;
  logic [DEPTH-1:0] video_out;
  logic             hsync;
  logic             vsync;
  logic             de;
  logic             frame_drop;
`ifdef ROTATE_MIRROR_EN
  logic             mirror;
  modport master (output ce_in, video_in, hblank, vblank, rot, ce_out, mirror,
                  input video_out, hsync, vsync, de, frame_drop);
  modport slave  (input ce_in, video_in, hblank, vblank, rot, ce_out, mirror,
                  output video_out, hsync, vsync, de, frame_drop);
`else
  modport master (output ce_in, video_in, hblank, vblank, rot, ce_out,
                  input video_out, hsync, vsync, de, frame_drop);
  modport slave  (input ce_in, video_in, hblank, vblank, rot, ce_out,
                  output video_out, hsync, vsync, de, frame_drop);
`endif
endinterface

// File: rtl/screen_rotate_quad.sv
// screen_rotate_quad: double-buffered 0/90/180/270 frame rotator with its own output timing.
// Optional: define ROTATE_MIRROR_EN to add a per-frame horizontal mirror of each output line.
module screen_rotate_quad #(
  parameter int WIDTH     = 320,
  parameter int HEIGHT    = 240,
  parameter int DEPTH     = 8,
  parameter int HBL_LEN   = 16,
  parameter int VBL_LINES = 8,
  parameter int AW        = 18
) (
  input logic clk,
  input logic reset_n,
  screen_rotate_quad_if.slave bus
);
  localparam int XW = $clog2(WIDTH + 1);
  localparam int YW = $clog2(HEIGHT + 1);
  localparam int CW = $clog2(WIDTH + HEIGHT + HBL_LEN + VBL_LINES + 1);
  localparam logic [AW-1:0] A_ONE = AW'(1);
  localparam logic [AW-1:0] A_W   = AW'(WIDTH);
  localparam logic [AW-1:0] A_R   = AW'(WIDTH * HEIGHT);
  localparam logic [AW-1:0] A_LL  = AW'((HEIGHT - 1) * WIDTH);

  typedef enum logic [1:0] {IDLE, ACTIVE, HBL, VBL} state_t;

  state_t            st, st_n;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [AW-1:0]     line_off, waddr;
  logic              hb_d, vb_d, hb_rise, vb_rise, active_px, we;
  logic              wbuf, pend, pbuf, drop, busy_other;
  logic [DEPTH-1:0]  mem [2**AW];
  logic [DEPTH-1:0]  rdata;
  logic [CW-1:0]     cnt, row, ow_m1, oh_m1;
  logic              last_px, last_hb, last_ln, last_vc, last_vl, frame_end;
  logic              fstart, take, rbuf, rbuf_n, shown, swap;
  logic [AW-1:0]     addr, row_addr, cstep, rstep, base_n;
  logic [AW-1:0]     n_start, n_cstep, s_start, s_cstep, s_rstep;
  logic              de_q, hs_q, vs_q;

  // Source side: pixel position and write address in the current write buffer
  assign hb_rise   = bus.hblank & ~hb_d & ~bus.vblank;
  assign vb_rise   = bus.vblank & ~vb_d;
  assign active_px = bus.ce_in & ~bus.hblank & ~bus.vblank & (x < XW'(WIDTH));
  assign we        = active_px & (y < YW'(HEIGHT));
  assign waddr     = (wbuf ? A_R : '0) + line_off + AW'(x);

  // Writer position counters; line offset grows by WIDTH per line so no multiplier is needed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x        <= '0;
      y        <= '0;
      line_off <= '0;
      hb_d     <= 1'b1;
      vb_d     <= 1'b1;
    end else begin
      hb_d <= bus.hblank;
      vb_d <= bus.vblank;
      if (vb_rise) begin
        x        <= '0;
        y        <= '0;
        line_off <= '0;
      end else if (hb_rise) begin
        x <= '0;
        if (y < YW'(HEIGHT)) begin
          y        <= y + 1'b1;
          line_off <= line_off + A_W;
        end
      end else if (active_px) begin
        x <= x + 1'b1;
      end
    end
  end

  // The writer may only move to the other buffer when the reader will not be using it
  assign busy_other = (st_n != IDLE) & (rbuf_n != wbuf);

  // Buffer ownership: pending frame bookkeeping and drop reporting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wbuf <= 1'b0;
      pend <= 1'b0;
      pbuf <= 1'b0;
      drop <= 1'b0;
    end else begin
      drop <= vb_rise & pend & ~take;
      if (vb_rise) begin
        pend <= 1'b1;
        pbuf <= wbuf;
        if (!busy_other) wbuf <= ~wbuf;
      end else if (take) begin
        pend <= 1'b0;
      end
    end
  end

  // Frame store write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= bus.video_in;
  end

  // Frame store registered read port, stepped with the output timing
  always_ff @(posedge clk) begin
    if (bus.ce_out) rdata <= mem[addr];
  end

  // Reader geometry for the frame currently being shown
  assign ow_m1     = swap ? CW'(HEIGHT - 1) : CW'(WIDTH - 1);
  assign oh_m1     = swap ? CW'(WIDTH - 1) : CW'(HEIGHT - 1);
  assign last_px   = cnt == ow_m1;
  assign last_hb   = cnt == CW'(HBL_LEN - 1);
  assign last_ln   = row == oh_m1;
  assign last_vc   = cnt == ow_m1 + CW'(HBL_LEN);
  assign last_vl   = row == CW'(VBL_LINES - 1);
  assign frame_end = (st == VBL) & last_vc & last_vl;
  assign fstart    = bus.ce_out & ((st == IDLE) | frame_end) & (pend | shown);
  assign take      = fstart & pend;
  assign rbuf_n    = take ? pbuf : rbuf;
  assign base_n    = rbuf_n ? A_R : '0;

  // Scan origin and steps for the rotation being latched at frame start
  assign n_start = bus.rot == 2'd0 ? '0 : bus.rot == 2'd1 ? A_LL : bus.rot == 2'd2 ? A_R - A_ONE : A_W - A_ONE;
  assign n_cstep = bus.rot == 2'd0 ? A_ONE : bus.rot == 2'd1 ? -A_W : bus.rot == 2'd2 ? -A_ONE : A_W;
  assign s_rstep = bus.rot == 2'd0 ? A_W : bus.rot == 2'd1 ? A_ONE : bus.rot == 2'd2 ? -A_W : -A_ONE;
`ifdef ROTATE_MIRROR_EN
  logic [AW-1:0] m_start;
  assign m_start = bus.rot == 2'd0 ? A_W - A_ONE : bus.rot == 2'd1 ? '0 : bus.rot == 2'd2 ? A_R - A_W : A_R - A_ONE;
  assign s_start = bus.mirror ? m_start : n_start;
  assign s_cstep = bus.mirror ? -n_cstep : n_cstep;
`else
  assign s_start = n_start;
  assign s_cstep = n_cstep;
`endif

  // Reader state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) st <= IDLE;
    else          st <= st_n;
  end

  // Reader next state, advancing only on ce_out
  always_comb begin
    st_n = st;
    if (bus.ce_out) begin
      case (st)
        IDLE:    st_n = fstart ? ACTIVE : IDLE;
        ACTIVE:  st_n = last_px ? HBL : ACTIVE;
        HBL:     st_n = last_hb ? (last_ln ? VBL : ACTIVE) : HBL;
        VBL:     st_n = frame_end ? (fstart ? ACTIVE : IDLE) : VBL;
        default: st_n = IDLE;
      endcase
    end
  end

  // Reader counters and address walk: per-pixel column step, per-line row step
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      row      <= '0;
      addr     <= '0;
      row_addr <= '0;
      cstep    <= '0;
      rstep    <= '0;
      swap     <= 1'b0;
      rbuf     <= 1'b0;
      shown    <= 1'b0;
    end else if (bus.ce_out) begin
      if (fstart) begin
        cnt      <= '0;
        row      <= '0;
        addr     <= base_n + s_start;
        row_addr <= base_n + s_start;
        cstep    <= s_cstep;
        rstep    <= s_rstep;
        swap     <= bus.rot[0];
        rbuf     <= rbuf_n;
        shown    <= 1'b1;
      end else if (st == ACTIVE) begin
        cnt  <= last_px ? '0 : cnt + 1'b1;
        addr <= addr + cstep;
      end else if (st == HBL) begin
        cnt <= last_hb ? '0 : cnt + 1'b1;
        if (last_hb) begin
          row      <= last_ln ? '0 : row + 1'b1;
          row_addr <= row_addr + rstep;
          addr     <= row_addr + rstep;
        end
      end else if (st == VBL) begin
        cnt <= last_vc ? '0 : cnt + 1'b1;
        if (last_vc) row <= row + 1'b1;
      end
    end
  end

  // Timing outputs delayed one ce_out step to line up with the RAM read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      de_q <= 1'b0;
      hs_q <= 1'b0;
      vs_q <= 1'b1;
    end else if (bus.ce_out) begin
      de_q <= st == ACTIVE;
      hs_q <= st == HBL;
      vs_q <= (st == IDLE) | (st == VBL);
    end
  end

  assign bus.video_out  = de_q ? rdata : '0;
  assign bus.de         = de_q;
  assign bus.hsync      = hs_q;
  assign bus.vsync      = vs_q;
  assign bus.frame_drop = drop;
endmodule

// File: tb/tb_screen_rotate_quad.sv
// tb_screen_rotate_quad: directed checks of capture, four rotations, repeat, rot latching, reset and frame drop
module tb_screen_rotate_quad;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int HB = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic step = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   ce_mode = 0;
  int   div = 0;
  int   drop_cnt = 0;
  int   got [32];
  int   exp_tab [4][12] = '{
    '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11},
    '{8, 4, 0, 9, 5, 1, 10, 6, 2, 11, 7, 3},
    '{11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0},
    '{3, 7, 11, 2, 6, 10, 1, 5, 9, 0, 4, 8}
  };

  screen_rotate_quad_if #(.DEPTH(8)) bus ();

  screen_rotate_quad #(
    .WIDTH(W), .HEIGHT(H), .DEPTH(8), .HBL_LEN(HB), .VBL_LINES(1), .AW(5)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    div++;
    bus.ce_out = (ce_mode == 1) || (ce_mode == 2 && div % 4 == 0);
  end

  always @(posedge clk) step = bus.ce_out;

  always @(negedge clk) if (bus.frame_drop === 1'b1) drop_cnt++;

`ifdef ROTATE_MIRROR_EN
  initial bus.mirror = 1'b0;
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input int base);
    bus.vblank = 1'b0;
    bus.hblank = 1'b0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        bus.ce_in = 1'b1;
        bus.video_in = 8'(base + y * W + x);
        @(negedge clk);
      end
      bus.ce_in = 1'b0;
      bus.hblank = 1'b1;
      repeat (HB) @(negedge clk);
      bus.hblank = 1'b0;
    end
    bus.vblank = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic capture(input int chg_at, input logic [1:0] chg_rot,
                         output int n, output int lines, output int hs, output int vbl);
    int guard;
    logic pde;
    guard = 0;
    pde = 1'b0;
    n = 0;
    lines = 0;
    hs = 0;
    vbl = (bus.vsync === 1'b1) ? 1 : 0;
    while (bus.vsync !== 1'b0 && guard < 400) begin
      @(negedge clk);
      guard++;
      if (step && bus.vsync === 1'b1) vbl++;
    end
    while (bus.vsync === 1'b0 && guard < 400) begin
      if (step) begin
        if (bus.de === 1'b1) begin
          if (n < 32) got[n] = int'(bus.video_out);
          n++;
          if (!pde) lines++;
          if (n == chg_at) bus.rot = chg_rot;
        end
        if (bus.hsync === 1'b1) hs++;
        pde = bus.de;
      end
      @(negedge clk);
      guard++;
    end
    check("cap_timeout", int'(guard >= 400), 0);
  endtask

  task automatic check_frame(input string tag, input int r, input int base,
                             input int n, input int lines, input int hs);
    int ow, oh;
    ow = r[0] ? H : W;
    oh = r[0] ? W : H;
    check({tag, "_pixels"}, n, ow * oh);
    check({tag, "_lines"}, lines, oh);
    check({tag, "_hsync"}, hs, oh * HB);
    for (int i = 0; i < 12; i++)
      check($sformatf("%s_px%0d", tag, i), got[i], base + exp_tab[r][i]);
  endtask

  initial begin
    int n, lines, hs, vbl, bad, d0;
    bus.ce_in = 1'b0;
    bus.video_in = '0;
    bus.hblank = 1'b0;
    bus.vblank = 1'b1;
    bus.rot = 2'd0;
    ce_mode = 1;
    repeat (3) @(negedge clk);
    check("rst_video", int'(bus.video_out), 0);
    check("rst_hsync", int'(bus.hsync), 0);
    check("rst_vsync", int'(bus.vsync), 1);
    check("rst_de", int'(bus.de), 0);
    check("rst_drop", int'(bus.frame_drop), 0);
    reset_n = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.vsync !== 1'b1 || bus.de !== 1'b0) bad++;
    end
    check("idle_no_input", bad, 0);

    ce_mode = 0;
    repeat (2) @(negedge clk);
    send_frame(0);
    ce_mode = 1;
    capture(-1, 2'd0, n, lines, hs, vbl);
    check_frame("rot0", 0, 0, n, lines, hs);

    bus.rot = 2'd1;
    capture(-1, 2'd0, n, lines, hs, vbl);
    check("rot1_vbl", vbl, W + HB);
    check_frame("rot1", 1, 0, n, lines, hs);

    bus.rot = 2'd2;
    capture(-1, 2'd0, n, lines, hs, vbl);
    check("rot2_vbl", vbl, H + HB);
    check_frame("rot2", 2, 0, n, lines, hs);

    bus.rot = 2'd3;
    capture(5, 2'd0, n, lines, hs, vbl);
    check("rot3_vbl", vbl, W + HB);
    check_frame("rot3", 3, 0, n, lines, hs);

    capture(-1, 2'd0, n, lines, hs, vbl);
    check("after_chg_vbl", vbl, H + HB);
    check_frame("after_chg", 0, 0, n, lines, hs);

    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_vsync", int'(bus.vsync), 1);
    check("midrst_de", int'(bus.de), 0);
    check("midrst_hsync", int'(bus.hsync), 0);
    check("midrst_video", int'(bus.video_out), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.vsync !== 1'b1 || bus.de !== 1'b0) bad++;
    end
    check("midrst_buffers_invalid", bad, 0);

    ce_mode = 0;
    repeat (2) @(negedge clk);
    send_frame(100);
    d0 = drop_cnt;
    ce_mode = 2;
    fork
      begin
        capture(-1, 2'd0, n, lines, hs, vbl);
        check_frame("slow_f1", 0, 100, n, lines, hs);
      end
      begin
        repeat (8) @(negedge clk);
        send_frame(140);
        send_frame(180);
      end
    join
    capture(-1, 2'd0, n, lines, hs, vbl);
    check("drop_count", drop_cnt - d0, 1);
    check("slow_vbl", vbl, W + HB);
    check_frame("slow_f3", 0, 180, n, lines, hs);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/screen_rotate_quad.md
Name: screen_rotate_quad

Overview:
- Single-clock, double-buffered frame rotator for the arcade video path.
- Captures a WIDTH x HEIGHT source frame and replays it rotated 0/90/180/270 degrees, selectable at run time.
- Generates its own output hsync/vsync/de timing for the downstream scaler.
- Generalises the fixed ±90 rotator: four modes, programmable blanking, frame-drop reporting, and all address arithmetic in one clock domain.

Parameters:
- WIDTH, 320, source active pixels per line.
- HEIGHT, 240, source active lines per frame.
- DEPTH, 8, pixel bits.
- HBL_LEN, 16, output blank ce_out cycles per line (≥2).
- VBL_LINES, 8, output blank lines per frame (≥1).
- AW, 18, RAM address bits; 2*WIDTH*HEIGHT ≤ 2^AW.

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset.
- ce_in  in  1  source pixel enable.
- video_in  in  DEPTH  source pixel.
- hblank  in  1  source horizontal blank.
- vblank  in  1  source vertical blank.
- rot  in  2  0 = none, 1 = 90 CW, 2 = 180, 3 = 270 CW.
- ce_out  in  1  output pixel enable.
- video_out  out  DEPTH  rotated pixel, 0 when de=0.
- hsync  out  1  output line blank.
- vsync  out  1  output frame blank.
- de  out  1  output data enable.
- frame_drop  out  1  one-clk pulse when a completed frame is discarded.

Behaviour:
- Reset: video_out=0, hsync=0, vsync=1, de=0, frame_drop=0. Both buffers invalid. Writer targets buffer 0. Reader is in IDLE.
- Writer:
  - Write occurs on ce_in & ~hblank & ~vblank & x<WIDTH & y<HEIGHT, at addr = base_w + y*WIDTH + x (incremental add, no multiplier).
  - hblank rising edge: x=0, y+=1.
  - Pixels with x≥WIDTH or y≥HEIGHT are ignored.
- Frame complete (vblank rising edge): write buffer becomes pending; x=y=0.
  - If the other buffer is not being read, the writer switches to it.
  - Otherwise the writer stays on the same buffer, overwriting the pending frame. frame_drop pulses when it overwrites an unread pending frame.
- Reader FSM (advances only on ce_out):
  - IDLE: vsync=1.
  - ACTIVE: OW pixels, de=1.
  - HBL: HBL_LEN cycles, hsync=1.
  - Line count: ACTIVE/HBL repeat for OH lines.
  - VBL: VBL_LINES*(OW+HBL_LEN) cycles, vsync=1.
  - Output dimensions: OW,OH = WIDTH,HEIGHT for rot 0/2; HEIGHT,WIDTH for rot 1/3.
- Frame start (leaving IDLE or VBL):
  - If a pending frame exists: swap to it and clear pending.
  - Else, if a frame was ever shown: repeat the current buffer.
  - Else: stay in IDLE.
  - rot (and mirror) are latched here; changes mid-frame take effect next frame.
- Read address = start + col*cstep per pixel; each new line = row_start + rstep. R = WIDTH*HEIGHT, offset by base_r:
  - rot0: start 0, cstep +1, rstep +WIDTH.
  - rot1: start (HEIGHT-1)*WIDTH, cstep -WIDTH, rstep +1.
  - rot2: start R-1, cstep -1, rstep -WIDTH.
  - rot3: start WIDTH-1, cstep +WIDTH, rstep -1.
- RAM: inferred simple dual-port, registered read, 1-clk latency. Timing outputs are delayed to match, so video_out, de, hsync and vsync are aligned and lag the FSM by one ce_out step.
- Simultaneous events: source vblank edge coincident with reader frame start → the reader sees the old pending state; the new frame is taken at the next frame start.
- reset_n low mid-frame: immediate return to reset state; buffers treated as invalid.

Optional Feature:
- ROTATE_MIRROR_EN defined: extra input port mirror (1 bit).
  - Latched with rot.
  - When 1, each output line is horizontally reversed: start moves to the line end and cstep is negated.
- Not defined: no port; behaviour is as above.

Test Plan:
- Reset release with no input, ce_out=1 → vsync stays 1, de=0 indefinitely.
- WIDTH=4, HEIGHT=3, rot=0, pixels 0..11, one frame → first output line 0,1,2,3; de high 4 cycles; 3 lines; then vsync.
- Same frame, rot=1 → OW=3, OH=4; lines 8,4,0 / 9,5,1 / 10,6,2 / 11,7,3.
- rot=2 → first line 11,10,9,8. rot=3 → first line 3,7,11; last line 0,4,8.
- ce_out slow, 3 source frames during one output frame → exactly one frame_drop pulse; next output frame shows frame 3.
- Source stops after one frame → output repeats the same frame; rot change mid-frame applies only at the next frame start.
